// File: rtl/mem_req_unit_if.sv
// Data-bus handshake between the memory request unit (master) and the data cache/bus (slave).
// One request in flight at a time; addr_ok accepts the address phase, data_ok completes the op.
interface mem_req_unit_if;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    logic [1:0]  size;
    logic [3:0]  strobe;
    logic [31:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } dbus_resp_t;

  dbus_req_t  dreq;
  dbus_resp_t dresp;

  modport master (output dreq, input dresp);
  modport slave  (input dreq, output dresp);

endinterface

// File: rtl/mem_req_unit.sv
// Memory stage request unit: computes the effective address, rejects misaligned ops,
// and drives a single outstanding load/store on the data bus, draining squashed ops.
package mem_req_unit_pkg;
  typedef enum logic [1:0] {
    MSIZE1 = 2'd0,
    MSIZE2 = 2'd1,
    MSIZE4 = 2'd2
  } msize_t;
endpackage

module mem_req_unit
  import mem_req_unit_pkg::*;
(
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 en,
  input  logic                 mem_read,
  input  logic                 mem_write,
  input  msize_t               msize,
  input  logic [31:0]          base,
  input  logic [31:0]          offset,
  input  logic [31:0]          wdata,
  input  logic                 flush,
  mem_req_unit_if.master       dbus,
  output logic                 mem_halt,
  output logic                 done,
  output logic [31:0]          rdata,
  output logic                 addr_error
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DRAIN} state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  msize_t      size_q, size_d;
  logic [3:0]  strobe_q, strobe_d;
  logic [31:0] data_q, data_d;
  logic        flushed_q, flushed_d;

  logic [31:0] eff_addr;
  logic        misaligned;
  logic [3:0]  strobe_n;
  logic [31:0] data_n;
  logic        accept;
  logic        kill;

  always_comb begin
    eff_addr   = base + offset;
    misaligned = 1'b0;
    strobe_n   = 4'b1111;
    data_n     = wdata;
    case (msize)
      MSIZE1: begin
        strobe_n = 4'b0001 << eff_addr[1:0];
        data_n   = {4{wdata[7:0]}};
      end
      MSIZE2: begin
        misaligned = eff_addr[0];
        strobe_n   = eff_addr[1] ? 4'b1100 : 4'b0011;
        data_n     = {2{wdata[15:0]}};
      end
      default: misaligned = |eff_addr[1:0];
    endcase
    if (!mem_write) strobe_n = '0;
  end

  assign accept     = en & (mem_read | mem_write) & (state_q == IDLE) & ~flush & ~misaligned;
  assign addr_error = en & (mem_read | mem_write) & (state_q == IDLE) & ~flush & misaligned;
  // A flush seen while the address phase is still pending must survive until addr_ok.
  assign kill       = flush | flushed_q;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    size_d    = size_q;
    strobe_d  = strobe_q;
    data_d    = data_q;
    flushed_d = flushed_q;
    done      = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d   = REQ;
          addr_d    = eff_addr;
          size_d    = msize;
          strobe_d  = strobe_n;
          data_d    = data_n;
          flushed_d = 1'b0;
        end
      end
      REQ: begin
        if (flush) flushed_d = 1'b1;
        if (dbus.dresp.addr_ok) begin
          flushed_d = 1'b0;
          if (dbus.dresp.data_ok) begin
            done    = ~kill;
            state_d = IDLE;
          end else begin
            state_d = kill ? DRAIN : WAIT;
          end
        end
      end
      WAIT: begin
        if (dbus.dresp.data_ok) begin
          done    = ~flush;
          state_d = IDLE;
        end else if (flush) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (dbus.dresp.data_ok) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      size_q    <= MSIZE1;
      strobe_q  <= '0;
      data_q    <= '0;
      flushed_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      size_q    <= size_d;
      strobe_q  <= strobe_d;
      data_q    <= data_d;
      flushed_q <= flushed_d;
    end
  end

  assign dbus.dreq.valid  = (state_q == REQ);
  assign dbus.dreq.addr   = addr_q;
  assign dbus.dreq.size   = size_q;
  assign dbus.dreq.strobe = strobe_q;
  assign dbus.dreq.data   = data_q;

  assign rdata    = done ? dbus.dresp.data : '0;
  assign mem_halt = accept | (((state_q == REQ) | (state_q == WAIT)) & ~done) | (state_q == DRAIN);

endmodule

// File: tb/tb_mem_req_unit.sv
// Directed bench for mem_req_unit: vector table of single ops plus hand sequences
// for flush, done-cycle acceptance and mid-transaction reset.
module tb_mem_req_unit;
  import mem_req_unit_pkg::*;

  logic        clk;
  logic        resetn;
  logic        en;
  logic        mem_read;
  logic        mem_write;
  msize_t      msize;
  logic [31:0] base;
  logic [31:0] offset;
  logic [31:0] wdata;
  logic        flush;
  logic        mem_halt;
  logic        done;
  logic [31:0] rdata;
  logic        addr_error;

  mem_req_unit_if bus();

  mem_req_unit dut (
    .clk        (clk),
    .resetn     (resetn),
    .en         (en),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .msize      (msize),
    .base       (base),
    .offset     (offset),
    .wdata      (wdata),
    .flush      (flush),
    .dbus       (bus),
    .mem_halt   (mem_halt),
    .done       (done),
    .rdata      (rdata),
    .addr_error (addr_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  typedef struct {
    logic [31:0] base;
    logic [31:0] offset;
    logic [31:0] wdata;
    msize_t      msize;
    logic        wr;
    int          a_lat;
    int          d_lat;
    logic [31:0] rd;
    logic        err;
    logic [31:0] e_addr;
    logic [3:0]  e_strobe;
    logic [31:0] e_data;
  } vec_t;

  vec_t vecs[10];

  function automatic vec_t mk(input logic [31:0] b, input logic [31:0] o, input logic [31:0] w,
                              input msize_t s, input logic wr, input int al, input int dl,
                              input logic [31:0] rd, input logic err, input logic [31:0] ea,
                              input logic [3:0] es, input logic [31:0] ed);
    vec_t v;
    v.base = b; v.offset = o; v.wdata = w; v.msize = s; v.wr = wr;
    v.a_lat = al; v.d_lat = dl; v.rd = rd; v.err = err;
    v.e_addr = ea; v.e_strobe = es; v.e_data = ed;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    en = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    flush = 1'b0; bus.dresp = '0;
  endtask

  task automatic drive_op(input logic [31:0] b, input logic [31:0] o, input logic [31:0] w,
                          input msize_t s, input logic wr);
    en = 1'b1; base = b; offset = o; wdata = w; msize = s;
    mem_write = wr; mem_read = ~wr; flush = 1'b0;
  endtask

  // Entered and left at 1 time unit after a rising edge with the DUT idle.
  task automatic run_vec(input int idx, input vec_t v);
    logic [31:0] exp_size;
    exp_size = {30'd0, v.msize};
    bus.dresp = '0;
    drive_op(v.base, v.offset, v.wdata, v.msize, v.wr);
    #1;
    chk($sformatf("v%0d addr_error", idx), addr_error, v.err);
    chk($sformatf("v%0d halt_accept", idx), mem_halt, !v.err);
    chk($sformatf("v%0d valid_idle", idx), bus.dreq.valid, 0);
    tick();
    idle_inputs();
    #1;
    if (v.err) begin
      chk($sformatf("v%0d valid_after_err", idx), bus.dreq.valid, 0);
      chk($sformatf("v%0d halt_after_err", idx), mem_halt, 0);
      tick();
      return;
    end
    chk($sformatf("v%0d valid", idx), bus.dreq.valid, 1);
    chk($sformatf("v%0d addr", idx), bus.dreq.addr, v.e_addr);
    chk($sformatf("v%0d strobe", idx), bus.dreq.strobe, v.e_strobe);
    chk($sformatf("v%0d data", idx), bus.dreq.data, v.e_data);
    chk($sformatf("v%0d size", idx), bus.dreq.size, exp_size);
    for (int c = 0; c < v.a_lat; c++) begin
      chk($sformatf("v%0d valid_hold", idx), bus.dreq.valid, 1);
      chk($sformatf("v%0d addr_hold", idx), bus.dreq.addr, v.e_addr);
      chk($sformatf("v%0d halt_req", idx), mem_halt, 1);
      chk($sformatf("v%0d done_early", idx), done, 0);
      tick();
      #1;
    end
    bus.dresp.addr_ok = 1'b1;
    bus.dresp.data_ok = (v.d_lat == 0);
    bus.dresp.data    = v.rd;
    #1;
    if (v.d_lat == 0) begin
      chk($sformatf("v%0d done", idx), done, 1);
      chk($sformatf("v%0d rdata", idx), rdata, v.rd);
      chk($sformatf("v%0d halt_done", idx), mem_halt, 0);
      tick();
      bus.dresp = '0;
    end else begin
      chk($sformatf("v%0d done_addr_only", idx), done, 0);
      chk($sformatf("v%0d rdata_not_done", idx), rdata, 0);
      chk($sformatf("v%0d halt_addr_only", idx), mem_halt, 1);
      tick();
      bus.dresp = '0;
      for (int c = 0; c < v.d_lat - 1; c++) begin
        #1;
        chk($sformatf("v%0d wait_done", idx), done, 0);
        chk($sformatf("v%0d wait_halt", idx), mem_halt, 1);
        chk($sformatf("v%0d wait_valid", idx), bus.dreq.valid, 0);
        tick();
      end
      bus.dresp.data_ok = 1'b1;
      bus.dresp.data    = v.rd;
      #1;
      chk($sformatf("v%0d done", idx), done, 1);
      chk($sformatf("v%0d rdata", idx), rdata, v.rd);
      chk($sformatf("v%0d halt_done", idx), mem_halt, 0);
      tick();
      bus.dresp = '0;
    end
    #1;
    chk($sformatf("v%0d done_once", idx), done, 0);
    chk($sformatf("v%0d idle_valid", idx), bus.dreq.valid, 0);
    chk($sformatf("v%0d idle_halt", idx), mem_halt, 0);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = mk(32'h1000, 32'h3, 32'hAB, MSIZE1, 1'b1, 1, 0, 32'h0, 1'b0,
                 32'h1003, 4'b1000, 32'hABABABAB);
    vecs[1] = mk(32'h2000, 32'h0, 32'h55667788, MSIZE4, 1'b0, 3, 2, 32'hDEADBEEF, 1'b0,
                 32'h2000, 4'b0000, 32'h55667788);
    vecs[2] = mk(32'h2000, 32'h1, 32'h0, MSIZE2, 1'b0, 0, 0, 32'h0, 1'b1,
                 32'h0, 4'b0000, 32'h0);
    vecs[3] = mk(32'hFFFFFFFC, 32'h8, 32'hCAFEF00D, MSIZE4, 1'b1, 0, 1, 32'h0, 1'b0,
                 32'h4, 4'b1111, 32'hCAFEF00D);
    vecs[4] = mk(32'h2000, 32'h2, 32'h0, MSIZE4, 1'b1, 0, 0, 32'h0, 1'b1,
                 32'h0, 4'b0000, 32'h0);
    vecs[5] = mk(32'h10, 32'h2, 32'hFFFF5678, MSIZE2, 1'b1, 0, 0, 32'h0, 1'b0,
                 32'h12, 4'b1100, 32'h56785678);
    vecs[6] = mk(32'h100, 32'h1, 32'h11, MSIZE1, 1'b0, 2, 0, 32'h000000A5, 1'b0,
                 32'h101, 4'b0000, 32'h11111111);
    vecs[7] = mk(32'h80000000, 32'h7FFFFFFC, 32'hBEEF, MSIZE2, 1'b1, 1, 1, 32'h0, 1'b0,
                 32'hFFFFFFFC, 4'b0011, 32'hBEEFBEEF);
    vecs[8] = mk(32'h30, 32'h2, 32'hC3, MSIZE1, 1'b1, 0, 0, 32'h0, 1'b0,
                 32'h32, 4'b0100, 32'hC3C3C3C3);
    vecs[9] = mk(32'h1004, 32'hFFFFFFFF, 32'h0, MSIZE4, 1'b0, 0, 0, 32'h0, 1'b1,
                 32'h0, 4'b0000, 32'h0);

    resetn = 1'b0;
    base = '0; offset = '0; wdata = '0; msize = MSIZE1;
    idle_inputs();
    #2;
    chk("reset valid", bus.dreq.valid, 0);
    chk("reset addr", bus.dreq.addr, 0);
    chk("reset strobe", bus.dreq.strobe, 0);
    chk("reset data", bus.dreq.data, 0);
    chk("reset done", done, 0);
    chk("reset rdata", rdata, 0);
    chk("reset addr_error", addr_error, 0);
    chk("reset halt", mem_halt, 0);
    tick();
    resetn = 1'b1;

    for (int i = 0; i < 10; i++) run_vec(i, vecs[i]);

    // Flush in IDLE: ignored op, no error even when misaligned.
    drive_op(32'h40, 32'h0, 32'h0, MSIZE4, 1'b0);
    flush = 1'b1;
    #1;
    chk("idle_flush halt", mem_halt, 0);
    chk("idle_flush addr_error", addr_error, 0);
    offset = 32'h1;
    #1;
    chk("idle_flush_mis addr_error", addr_error, 0);
    tick();
    idle_inputs();
    #1;
    chk("idle_flush no_valid", bus.dreq.valid, 0);
    tick();

    // Flush in REQ; address accepted two cycles later, then drained.
    drive_op(32'h40, 32'h0, 32'h0, MSIZE4, 1'b0);
    tick();
    idle_inputs();
    flush = 1'b1;
    #1;
    chk("req_flush valid", bus.dreq.valid, 1);
    tick();
    flush = 1'b0;
    #1;
    chk("req_flush valid_held", bus.dreq.valid, 1);
    chk("req_flush halt", mem_halt, 1);
    tick();
    bus.dresp.addr_ok = 1'b1;
    #1;
    chk("req_flush valid_at_aok", bus.dreq.valid, 1);
    chk("req_flush done_at_aok", done, 0);
    tick();
    bus.dresp = '0;
    bus.dresp.data_ok = 1'b1;
    bus.dresp.data = 32'h99;
    #1;
    chk("drain valid", bus.dreq.valid, 0);
    chk("drain done", done, 0);
    chk("drain rdata", rdata, 0);
    chk("drain halt", mem_halt, 1);
    tick();
    bus.dresp = '0;
    #1;
    chk("drain exit halt", mem_halt, 0);
    chk("drain exit done", done, 0);
    tick();

    // Flush in REQ with addr_ok and data_ok together: straight to IDLE, no done.
    drive_op(32'h44, 32'h0, 32'h0, MSIZE4, 1'b0);
    tick();
    idle_inputs();
    flush = 1'b1;
    bus.dresp.addr_ok = 1'b1; bus.dresp.data_ok = 1'b1; bus.dresp.data = 32'h77;
    #1;
    chk("req_flush_both done", done, 0);
    chk("req_flush_both rdata", rdata, 0);
    tick();
    idle_inputs();
    #1;
    chk("req_flush_both idle halt", mem_halt, 0);
    tick();

    // Flush in WAIT: drain, done suppressed.
    drive_op(32'h48, 32'h0, 32'h0, MSIZE4, 1'b0);
    tick();
    idle_inputs();
    bus.dresp.addr_ok = 1'b1;
    #1;
    tick();
    bus.dresp = '0;
    flush = 1'b1;
    #1;
    chk("wait_flush done", done, 0);
    tick();
    flush = 1'b0;
    bus.dresp.data_ok = 1'b1; bus.dresp.data = 32'h55;
    #1;
    chk("wait_flush drain done", done, 0);
    chk("wait_flush drain halt", mem_halt, 1);
    tick();
    bus.dresp = '0;
    #1;
    chk("wait_flush idle halt", mem_halt, 0);
    tick();

    // Op held on en across the done cycle is accepted only in the cycle after.
    drive_op(32'h500, 32'h0, 32'h12345678, MSIZE4, 1'b1);
    tick();
    bus.dresp.addr_ok = 1'b1; bus.dresp.data_ok = 1'b1;
    #1;
    chk("b2b done", done, 1);
    chk("b2b halt_in_done", mem_halt, 0);
    tick();
    bus.dresp = '0;
    #1;
    chk("b2b no_accept_in_done", bus.dreq.valid, 0);
    chk("b2b accept_halt", mem_halt, 1);
    tick();
    idle_inputs();
    #1;
    chk("b2b second valid", bus.dreq.valid, 1);
    bus.dresp.addr_ok = 1'b1; bus.dresp.data_ok = 1'b1;
    #1;
    chk("b2b second done", done, 1);
    tick();
    bus.dresp = '0;
    #1;
    chk("b2b idle valid", bus.dreq.valid, 0);
    tick();

    // Reset while in WAIT: outputs clear immediately, no drain afterwards.
    drive_op(32'h600, 32'h0, 32'h0, MSIZE4, 1'b0);
    tick();
    idle_inputs();
    bus.dresp.addr_ok = 1'b1;
    #1;
    tick();
    bus.dresp = '0;
    bus.dresp.data_ok = 1'b1; bus.dresp.data = 32'h1111;
    resetn = 1'b0;
    #1;
    chk("rst_wait valid", bus.dreq.valid, 0);
    chk("rst_wait addr", bus.dreq.addr, 0);
    chk("rst_wait strobe", bus.dreq.strobe, 0);
    chk("rst_wait data", bus.dreq.data, 0);
    chk("rst_wait done", done, 0);
    chk("rst_wait rdata", rdata, 0);
    chk("rst_wait halt", mem_halt, 0);
    tick();
    bus.dresp = '0;
    resetn = 1'b1;
    run_vec(100, mk(32'h3000, 32'h2, 32'h1234, MSIZE2, 1'b1, 0, 0, 32'h0, 1'b0,
                    32'h3002, 4'b1100, 32'h12341234));

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
